// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - command FIFO feeding an external combinational ALU
// One command executes at a time; each result is held until the consumer takes it.
module alu_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [W-1:0]             in_b,
  input  logic [3:0]               in_sel,
  output logic [W-1:0]             alu_a,
  output logic [W-1:0]             alu_b,
  output logic [3:0]               alu_sel,
  input  logic [W-1:0]             alu_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_c,
  output logic [3:0]               out_sel,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 2 * W + 4;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [DW-1:0]  r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [3:0]     r_alu_sel;
  logic [W-1:0]   r_out_c;
  logic [3:0]     r_out_sel;
  logic           r_out_err;

  logic           w_in_ready;
  logic           w_push;
  logic           w_pop;
  logic           w_capture;
  logic           w_has_cmd;
  logic           w_illegal;
  logic [DW-1:0]  w_head;

  // in_ready looks only at the registered count, so a same-cycle pop never frees a slot early
  assign w_in_ready = (r_count < CW'(DEPTH));
  assign w_push     = in_valid & w_in_ready;
  assign w_has_cmd  = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_illegal  = (r_alu_sel > 4'b1011);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_has_cmd ? S_EXEC : S_IDLE;
      S_EXEC:  w_next = S_RESP;
      S_RESP: begin
        if (out_ready) begin
          w_next = w_has_cmd ? S_EXEC : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE:  w_pop     = w_has_cmd;
      S_EXEC:  w_capture = 1'b1;
      S_RESP:  w_pop     = out_ready & w_has_cmd;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b, in_sel};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_out_c   <= '0;
      r_out_sel <= '0;
      r_out_err <= 1'b0;
    end else begin
      if (w_pop) begin
        r_alu_a   <= w_head[DW-1 -: W];
        r_alu_b   <= w_head[W+3 -: W];
        r_alu_sel <= w_head[3:0];
      end
      // An illegal opcode still produces a result, but with the ALU output masked off
      if (w_capture) begin
        r_out_c   <= w_illegal ? '0 : alu_c;
        r_out_sel <= r_alu_sel;
        r_out_err <= w_illegal;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign out_valid = (r_state == S_RESP);
  assign out_c     = r_out_c;
  assign out_sel   = r_out_sel;
  assign out_err   = r_out_err;
  assign count     = r_count;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb/tb_alu_cmd_queue.sv - directed and randomized checks of alu_cmd_queue against a queue model
module tb_alu_cmd_queue;

  localparam int DEPTH = 4;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_sel;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_c;
  logic [3:0]   out_sel;
  logic         out_err;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } cmd_t;

  typedef struct {
    logic [7:0] c;
    logic [3:0] sel;
    logic       err;
    int         cyc;
  } res_t;

  cmd_t exp_q[$];
  res_t res_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  logic last_push;

  always #5 clk = ~clk;

  // Team ALU behaviour; illegal opcodes return a junk pattern the queue must mask
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return {7'd0, a == b};
      4'd6:    return {7'd0, a != b};
      4'd7:    return {7'd0, a < b};
      4'd8:    return ~a;
      4'd9:    return a << 1;
      4'd10:   return {7'd0, a > b};
      4'd11:   return a >> 1;
      default: return 8'hA5;
    endcase
  endfunction

  assign alu_c = alu_f(alu_a, alu_b, alu_sel);

  alu_cmd_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_c     (alu_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: sample handshakes before the edge, then update the model after it
  task automatic tick();
    logic push_ok, hs;
    cmd_t pc, e;
    logic [7:0] oc;
    logic [3:0] os;
    logic       oe;
    push_ok = in_valid && in_ready;
    hs      = out_valid && out_ready;
    pc      = '{in_a, in_b, in_sel};
    oc = out_c; os = out_sel; oe = out_err;
    @(posedge clk);
    #1;
    cyc++;
    last_push = push_ok;
    if (push_ok) exp_q.push_back(pc);
    if (hs) begin
      res_q.push_back('{oc, os, oe, cyc});
      n_total++;
      assert (exp_q.size() != 0) n_pass++;
      else $error("FAIL spurious_result: observed out_c %0h with no command outstanding", oc);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_out_c", {24'd0, oc}, {24'd0, (e.sel > 4'd11) ? 8'h00 : alu_f(e.a, e.b, e.sel)});
        chk("sb_out_sel", {28'd0, os}, {28'd0, e.sel});
        chk("sb_out_err", {31'd0, oe}, {31'd0, e.sel > 4'd11});
      end
    end
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    in_a = a; in_b = b; in_sel = s; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_push) break;
    end
    in_valid = 1'b0;
    chk("push_accepted", {31'd0, last_push}, 32'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_a"}, {24'd0, alu_a}, 32'd0);
    chk({tag, "_alu_b"}, {24'd0, alu_b}, 32'd0);
    chk({tag, "_alu_sel"}, {28'd0, alu_sel}, 32'd0);
    chk({tag, "_out_c"}, {24'd0, out_c}, 32'd0);
    chk({tag, "_out_sel"}, {28'd0, out_sel}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_err"}, {31'd0, out_err}, 32'd0);
    chk({tag, "_count"}, {29'd0, count}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] exp35 [4];
    exp35[0] = 8'hFF; exp35[1] = 8'hE1; exp35[2] = 8'h00; exp35[3] = 8'hFF;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Latency from an empty queue; the push lands on the first edge out of reset
    in_a = 8'h0F; in_b = 8'h01; in_sel = 4'b0000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_first_push", {31'd0, last_push}, 32'd1);
    chk("lat_k_count", {29'd0, count}, 32'd1);
    chk("lat_k_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_k1_alu_a", {24'd0, alu_a}, 32'h0F);
    chk("lat_k1_alu_b", {24'd0, alu_b}, 32'h01);
    chk("lat_k1_alu_sel", {28'd0, alu_sel}, 32'd0);
    chk("lat_k1_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_k2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_k2_out_c", {24'd0, out_c}, 32'h10);
    chk("lat_k2_out_sel", {28'd0, out_sel}, 32'd0);
    chk("lat_k2_out_err", {31'd0, out_err}, 32'd0);
    tick();
    chk("lat_consumed", {31'd0, out_valid}, 32'd0);

    // Back-to-back commands, one result every two cycles
    res_q.delete();
    for (int i = 0; i < 4; i++) push_cmd(8'hF0, 8'h0F, 4'(i));
    drain();
    chk("b2b_count", res_q.size(), 32'd4);
    for (int i = 0; i < res_q.size() && i < 4; i++) begin
      chk($sformatf("b2b_c%0d", i), {24'd0, res_q[i].c}, {24'd0, exp35[i]});
      if (i > 0) chk($sformatf("b2b_gap%0d", i), res_q[i].cyc - res_q[i-1].cyc, 32'd2);
    end

    // Fill while the consumer stalls, then check full behaviour
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(8'(8'h10 + i), 8'(3 * i), 4'(i));
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_a = 8'h77; in_b = 8'h11; in_sel = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_held_push", {31'd0, last_push}, 32'd0);
      chk("full_held_count", {29'd0, count}, 32'd4);
    end
    out_ready = 1'b1;
    tick();
    chk("full_pop_no_push", {31'd0, last_push}, 32'd0);
    chk("full_pop_count", {29'd0, count}, 32'd3);
    tick();
    chk("full_late_push", {31'd0, last_push}, 32'd1);
    drain();

    // Legal compare versus illegal opcode
    res_q.delete();
    push_cmd(8'h15, 8'h15, 4'b0101);
    push_cmd(8'h15, 8'h15, 4'b1110);
    drain();
    chk("ill_count", res_q.size(), 32'd2);
    if (res_q.size() == 2) begin
      chk("ill_legal_c", {24'd0, res_q[0].c}, 32'h01);
      chk("ill_legal_err", {31'd0, res_q[0].err}, 32'd0);
      chk("ill_bad_c", {24'd0, res_q[1].c}, 32'h00);
      chk("ill_bad_err", {31'd0, res_q[1].err}, 32'd1);
      chk("ill_bad_sel", {28'd0, res_q[1].sel}, 32'hE);
    end

    // Reset while a command is executing
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(8'(8'h40 + i), 8'h01, 4'd0);
    out_ready = 1'b1;
    tick();
    chk("rst_pre_count", {29'd0, count}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst_count", {29'd0, count}, 32'd0);
    end

    // Long consumer stall holds the result stable
    out_ready = 1'b0;
    push_cmd(8'h30, 8'h15, 4'b1010);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out_c", {24'd0, out_c}, 32'h01);
      chk("stall_out_sel", {28'd0, out_sel}, 32'hA);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release", {31'd0, out_valid}, 32'd0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_sel    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
